// File: rtl/hangman_pkg.sv
// Shared types and helpers for the hangman game sequencer: letter coding and FSM states.
package hangman_pkg;
    localparam int CHAR_W = 5;
    localparam logic [CHAR_W-1:0] LETTER_A = CHAR_W'(1);
    localparam logic [CHAR_W-1:0] LETTER_Z = CHAR_W'(26);

    typedef enum logic [3:0] {
        ENTER,
        LOAD,
        LATCH,
        WAIT_G,
        COMPARE,
        FILL,
        SCORE,
        WIN,
        LOSE,
        ERR
    } state_t;

    function automatic logic is_letter(input logic [CHAR_W-1:0] code);
        return (code >= LETTER_A) && (code <= LETTER_Z);
    endfunction
endpackage

// File: rtl/hangman_control_used_letter_mask.sv
// One bit per letter A..Z remembering which guesses were already played.
module used_letter_mask
    import hangman_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              set,
    input  logic [CHAR_W-1:0] code,
    output logic              hit
);
    localparam int N = int'(LETTER_Z);

    logic [N-1:0] mask;
    logic [N-1:0] sel;

    // Invalid codes decode to an all-zero select, so they never hit or set.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            sel[i] = (code == CHAR_W'(i + 1));
        end
    end

    assign hit = |(mask & sel);

    always_ff @(posedge clk) begin
        if (resetn) begin
            mask <= '0;
        end else if (set) begin
            mask <= mask | sel;
        end
    end
endmodule

// File: rtl/hangman_control.sv
// Game sequencer for the hangman datapath: word entry, guess handling, lives and win/lose.
module hangman_control
    import hangman_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LIVES   = 6,
    parameter int WDOG    = 24
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              key_valid,
    input  logic [CHAR_W-1:0] key_char,
    input  logic              key_enter,
    input  logic              loopend,
    input  logic              match,
    input  logic              filled,
    input  logic [CHAR_W-1:0] remain,
    output logic              ld,
    output logic              ld_g,
    output logic              wren,
    output logic              rden,
    output logic              writeorread,
    output logic              compare,
    output logic              fill,
    output logic [CHAR_W-1:0] char,
    output logic [CHAR_W-1:0] guess,
    output logic [2:0]        lives,
    output logic              dup_guess,
    output logic              overflow,
    output logic              win,
    output logic              lose,
    output logic              err
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int WD_W  = $clog2(WDOG + 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [WD_W-1:0]  WDOG_LAST = WD_W'(WDOG - 1);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [WD_W-1:0]  wdog;
    logic             guess_ok;
    logic             hit;
    logic             set_used;

    assign guess_ok = key_valid && is_letter(key_char);
    assign set_used = (state == WAIT_G) && guess_ok && !hit;

    // Both derived strobes come straight from registers, so outputs stay registered.
    assign wren = ld;
    assign rden = compare | fill;

    used_letter_mask u_used (
        .clk    (clk),
        .resetn (resetn),
        .set    (set_used),
        .code   (key_char),
        .hit    (hit)
    );

    always_ff @(posedge clk) begin
        if (resetn) begin
            state       <= ENTER;
            len         <= '0;
            wdog        <= '0;
            ld          <= 1'b0;
            ld_g        <= 1'b0;
            writeorread <= 1'b1;
            compare     <= 1'b0;
            fill        <= 1'b0;
            char        <= '0;
            guess       <= '0;
            lives       <= 3'(LIVES);
            dup_guess   <= 1'b0;
            overflow    <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
            err         <= 1'b0;
        end else begin
            ld        <= 1'b0;
            ld_g      <= 1'b0;
            dup_guess <= 1'b0;
            case (state)
                // A letter takes priority over a simultaneous enter.
                ENTER: begin
                    if (guess_ok) begin
                        if (len < LEN_MAX) begin
                            state <= LOAD;
                            ld    <= 1'b1;
                            char  <= key_char;
                            len   <= len + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (key_enter && (len != '0)) begin
                        state <= LATCH;
                        ld_g  <= 1'b1;
                    end
                end
                LOAD: state <= ENTER;
                LATCH: begin
                    writeorread <= 1'b0;
                    state       <= WAIT_G;
                end
                WAIT_G: begin
                    if (guess_ok) begin
                        if (hit) begin
                            dup_guess <= 1'b1;
                        end else begin
                            guess   <= key_char;
                            compare <= 1'b1;
                            wdog    <= '0;
                            state   <= COMPARE;
                        end
                    end
                end
                // The watchdog keeps counting across COMPARE into FILL.
                COMPARE: begin
                    if (loopend) begin
                        compare <= 1'b0;
                        if (match) begin
                            fill  <= 1'b1;
                            wdog  <= wdog + 1'b1;
                            state <= FILL;
                        end else begin
                            if (lives != 3'd0) lives <= lives - 3'd1;
                            state <= SCORE;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        compare <= 1'b0;
                        err     <= 1'b1;
                        state   <= ERR;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                FILL: begin
                    if (filled) begin
                        fill  <= 1'b0;
                        state <= SCORE;
                    end else if (wdog == WDOG_LAST) begin
                        fill  <= 1'b0;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                SCORE: begin
                    if (remain == '0) begin
                        win   <= 1'b1;
                        state <= WIN;
                    end else if (lives == 3'd0) begin
                        lose  <= 1'b1;
                        state <= LOSE;
                    end else begin
                        state <= WAIT_G;
                    end
                end
                WIN, LOSE, ERR: state <= state;
                default: state <= ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_hangman_control.sv
// Directed bench for hangman_control with queue scoreboards for stored letters and guesses.
module tb_hangman_control;
    logic       clk = 1'b0;
    logic       resetn;
    logic       key_valid;
    logic [4:0] key_char;
    logic       key_enter;
    logic       loopend;
    logic       match;
    logic       filled;
    logic [4:0] remain;
    logic       ld, ld_g, wren, rden, writeorread, compare, fill;
    logic [4:0] char, guess;
    logic [2:0] lives;
    logic       dup_guess, overflow, win, lose, err;

    int tests = 0;
    int fails = 0;
    int ld_count = 0;
    logic compare_q = 1'b0;
    logic [4:0] exp_char[$];
    logic [4:0] exp_guess[$];

    always #5 clk = ~clk;

    hangman_control dut (
        .clk         (clk),
        .resetn      (resetn),
        .key_valid   (key_valid),
        .key_char    (key_char),
        .key_enter   (key_enter),
        .loopend     (loopend),
        .match       (match),
        .filled      (filled),
        .remain      (remain),
        .ld          (ld),
        .ld_g        (ld_g),
        .wren        (wren),
        .rden        (rden),
        .writeorread (writeorread),
        .compare     (compare),
        .fill        (fill),
        .char        (char),
        .guess       (guess),
        .lives       (lives),
        .dup_guess   (dup_guess),
        .overflow    (overflow),
        .win         (win),
        .lose        (lose),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) compare_q <= compare;

    // Scoreboard side: pop an expectation whenever the DUT emits a store or starts a compare.
    always @(negedge clk) begin
        if (ld === 1'b1) begin
            ld_count++;
            check("wren_follows_ld", wren, 1);
            if (exp_char.size() == 0) check("ld_unexpected", ld, 0);
            else check("ld_char", char, exp_char.pop_front());
        end
        if (compare === 1'b1 && compare_q !== 1'b1) begin
            if (exp_guess.size() == 0) check("compare_unexpected", compare, 0);
            else check("compare_guess", guess, exp_guess.pop_front());
        end
    end

    task automatic send_key(input logic [4:0] c, input logic en);
        key_valid = 1'b1; key_char = c; key_enter = en;
        @(negedge clk);
        key_valid = 1'b0; key_enter = 1'b0;
        @(negedge clk);
    endtask

    task automatic enter_word();
        key_enter = 1'b1;
        @(negedge clk);
        key_enter = 1'b0;
        check("latch_ld_g", ld_g, 1);
        @(negedge clk);
        check("wait_writeorread", writeorread, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
    endtask

    task automatic miss(input logic [4:0] c, input logic [2:0] exp_lives);
        key_valid = 1'b1; key_char = c; exp_guess.push_back(c);
        @(negedge clk);
        key_valid = 1'b0; loopend = 1'b1; match = 1'b0;
        @(negedge clk);
        loopend = 1'b0;
        check("miss_lives", lives, exp_lives);
        check("miss_compare_done", compare, 0);
        @(negedge clk);
    endtask

    initial begin
        int base;
        resetn = 1'b1; key_valid = 1'b0; key_char = '0; key_enter = 1'b0;
        loopend = 1'b0; match = 1'b0; filled = 1'b0; remain = 5'd2;
        do_reset();

        check("rst_ld", ld, 0);
        check("rst_ld_g", ld_g, 0);
        check("rst_wor", writeorread, 1);
        check("rst_lives", lives, 6);
        check("rst_char", char, 0);
        check("rst_guess", guess, 0);
        check("rst_flags", {dup_guess, overflow, win, lose, err}, 0);
        check("rst_strobes", {compare, fill, rden, wren}, 0);

        // Enter with an empty word does nothing; invalid codes are dropped.
        key_enter = 1'b1;
        @(negedge clk);
        key_enter = 1'b0;
        check("empty_enter_ld_g", ld_g, 0);
        @(negedge clk);
        check("empty_enter_wor", writeorread, 1);
        send_key(5'd0, 1'b0);
        send_key(5'd27, 1'b0);

        foreach (exp_char[i]) ; // keep scoreboard ordering explicit below
        exp_char.push_back(5'd3);  send_key(5'd3, 1'b0);
        exp_char.push_back(5'd1);  send_key(5'd1, 1'b0);
        exp_char.push_back(5'd20); send_key(5'd20, 1'b0);
        check("cat_ld_count", ld_count, 3);
        enter_word();
        check("cat_ld_g_done", ld_g, 0);

        // Hit on A: compare for two cycles, then fill until filled.
        key_valid = 1'b1; key_char = 5'd1; exp_guess.push_back(5'd1);
        @(negedge clk);
        key_valid = 1'b0;
        check("hit_latency_compare", compare, 1);
        check("hit_latency_rden", rden, 1);
        @(negedge clk);
        check("hit_compare_held", compare, 1);
        loopend = 1'b1; match = 1'b1;
        @(negedge clk);
        loopend = 1'b0; match = 1'b0;
        check("hit_fill", fill, 1);
        check("hit_compare_off", compare, 0);
        check("hit_fill_rden", rden, 1);
        @(negedge clk);
        check("hit_fill_held", fill, 1);
        @(negedge clk);
        check("hit_fill_held2", fill, 1);
        filled = 1'b1;
        @(negedge clk);
        filled = 1'b0;
        check("hit_fill_drop", fill, 0);
        check("hit_rden_drop", rden, 0);
        @(negedge clk);
        check("hit_lives", lives, 6);
        check("hit_no_win", win, 0);

        // Repeat of A is flagged and does not start a compare.
        key_valid = 1'b1; key_char = 5'd1;
        @(negedge clk);
        key_valid = 1'b0;
        check("dup_pulse", dup_guess, 1);
        check("dup_no_compare", compare, 0);
        @(negedge clk);
        check("dup_pulse_end", dup_guess, 0);
        check("dup_lives", lives, 6);

        miss(5'd2, 3'd5);
        miss(5'd4, 3'd4);
        miss(5'd5, 3'd3);
        miss(5'd6, 3'd2);
        miss(5'd7, 3'd1);
        check("not_lost_yet", lose, 0);
        miss(5'd8, 3'd0);
        check("lose_flag", lose, 1);
        send_key(5'd9, 1'b0);
        check("lose_ignores_key", compare, 0);
        check("lose_sticky", lose, 1);
        check("lose_lives", lives, 0);

        // Overflow: 17 letters into a 16-letter word; first one arrives with enter.
        do_reset();
        base = ld_count;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_char.push_back(5'(i + 1));
            if (i == 16) check("no_overflow_yet", overflow, 0);
            send_key(5'(i + 1), i == 0);
            if (i == 0) check("letter_beats_enter", ld_g, 0);
        end
        check("overflow_set", overflow, 1);
        check("overflow_ld_count", ld_count - base, 16);
        enter_word();

        // Guess that reveals the last letters leads to WIN.
        key_valid = 1'b1; key_char = 5'd5; exp_guess.push_back(5'd5);
        @(negedge clk);
        key_valid = 1'b0; loopend = 1'b1; match = 1'b1;
        @(negedge clk);
        loopend = 1'b0; match = 1'b0; filled = 1'b1; remain = 5'd0;
        @(negedge clk);
        filled = 1'b0;
        @(negedge clk);
        check("win_flag", win, 1);
        remain = 5'd2;
        send_key(5'd9, 1'b0);
        check("win_ignores_key", compare, 0);
        check("win_sticky", win, 1);

        // Watchdog: loopend never arrives.
        do_reset();
        exp_char.push_back(5'd7); send_key(5'd7, 1'b0);
        enter_word();
        key_valid = 1'b1; key_char = 5'd3; exp_guess.push_back(5'd3);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            key_valid = 1'b0;
            check("wdog_compare_held", {compare, err}, 2'b10);
        end
        @(negedge clk);
        check("wdog_err", err, 1);
        check("wdog_compare_off", compare, 0);
        check("wdog_rden_off", rden, 0);
        send_key(5'd4, 1'b0);
        check("err_ignores_key", compare, 0);

        // Reset in the middle of FILL.
        do_reset();
        exp_char.push_back(5'd7); send_key(5'd7, 1'b0);
        enter_word();
        key_valid = 1'b1; key_char = 5'd3; exp_guess.push_back(5'd3);
        @(negedge clk);
        key_valid = 1'b0; loopend = 1'b1; match = 1'b1;
        @(negedge clk);
        loopend = 1'b0; match = 1'b0;
        check("midfill_fill", fill, 1);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        check("midfill_rst_strobes", {fill, rden, compare, ld, ld_g}, 0);
        check("midfill_rst_wor", writeorread, 1);
        check("midfill_rst_lives", lives, 6);
        check("midfill_rst_guess", guess, 0);
        check("midfill_rst_char", char, 0);
        check("midfill_rst_flags", {dup_guess, overflow, win, lose, err}, 0);

        // Used-letter mask is cleared by reset: the same guess is accepted again.
        exp_char.push_back(5'd7); send_key(5'd7, 1'b0);
        enter_word();
        key_valid = 1'b1; key_char = 5'd3; exp_guess.push_back(5'd3);
        @(negedge clk);
        key_valid = 1'b0;
        check("post_reset_guess_compare", compare, 1);
        check("post_reset_no_dup", dup_guess, 0);
        @(negedge clk);

        check("char_queue_drained", exp_char.size(), 0);
        check("guess_queue_drained", exp_guess.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
